dmem: RTL and testbench

- Data memory for the single-cycle RISC-V core, sitting behind the ALU address path.
- Holds DEPTH 32-bit words.
- Reads are combinational, so data is returned in the same cycle. Writes commit on the rising clock edge when MemRW=1.
- Supports RV32I byte, halfword and word loads and stores, with sign or zero extension on loads.

---
 rtl/dmem_if.sv | 30 +++
 rtl/dmem.sv | 151 +++++++++++++++
 tb/tb_dmem.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store bus between the core's memory stage and dmem.
// The master drives address, store data, MemRW and funct3; dmem returns dataR and misalign combinationally.
interface dmem_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] addr;
    logic [31:0]       dataW;
    logic              MemRW;
    logic [2:0]        funct3;
    logic [31:0]       dataR;
    logic              misalign;

    modport master (
        output addr,
        output dataW,
        output MemRW,
        output funct3,
        input  dataR,
        input  misalign
    );

    modport slave (
        input  addr,
        input  dataW,
        input  MemRW,
        input  funct3,
        output dataR,
        output misalign
    );
endinterface

// File: rtl/dmem.sv
// Single-cycle RV32I data memory: combinational loads, clocked byte/half/word stores, async clear.
// Define DMEM_BOUNDS_CHECK_EN to fault (misalign=1, dataR=0, store dropped) on addresses above the array.
module dmem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int BYTE_AW = IDX_W + 2;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d;
    logic             wr_ok_q;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    size_e            size;
    logic             f3_legal;
    logic             align_err;
    logic             out_of_range;
    logic             access_err;
    logic             wr_en;

    logic [31:0]      rd_word;
    logic [15:0]      rd_half;
    logic [7:0]       rd_byte;
    logic [31:0]      load_data;
    logic [31:0]      wr_data;
    logic [3:0]       byte_en;

    assign idx  = bus.addr[BYTE_AW-1:2];
    assign lane = bus.addr[1:0];
    assign size = size_e'(bus.funct3[1:0]);

    always_comb begin
        f3_legal = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
            default:                                f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        align_err = 1'b0;
        case (size)
            SZ_H:    align_err = lane[0];
            SZ_W:    align_err = (lane != 2'b00);
            default: align_err = 1'b0;
        endcase
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign out_of_range = |(bus.addr >> BYTE_AW);
`else
    // Upper address bits deliberately ignored: the address wraps modulo DEPTH*4 bytes.
    logic [ADDR_W-1:0] unused_addr_hi;
    assign unused_addr_hi = bus.addr >> BYTE_AW;
    assign out_of_range   = 1'b0;
`endif

    assign access_err   = !f3_legal || align_err || out_of_range;
    assign bus.misalign = access_err;

    // Read path
    assign rd_word = mem_q[idx];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    always_comb begin
        load_data = '0;
        case (bus.funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'd0, rd_half};
            3'b010:  load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    assign bus.dataR = (!rst_n || access_err) ? 32'd0 : load_data;

    // Write path: replicate store data across lanes, then merge the enabled bytes into the old word.
    always_comb begin
        wr_data = bus.dataW;
        byte_en = 4'b0000;
        case (size)
            SZ_B: begin
                wr_data = {4{bus.dataW[7:0]}};
                byte_en = 4'b0001 << lane;
            end
            SZ_H: begin
                wr_data = {2{bus.dataW[15:0]}};
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
            end
            SZ_W: begin
                wr_data = bus.dataW;
                byte_en = 4'b1111;
            end
            default: begin
                wr_data = bus.dataW;
                byte_en = 4'b0000;
            end
        endcase
    end

    always_comb begin
        mem_d = rd_word;
        for (int k = 0; k < 4; k++) begin
            if (byte_en[k]) begin
                mem_d[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // wr_ok_q opens one edge after reset release, so an edge coincident with deassertion never writes.
    assign wr_en = bus.MemRW && !access_err && wr_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ok_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ok_q <= 1'b1;
            if (wr_en) begin
                mem_q[idx] <= mem_d;
            end
        end
    end
endmodule

// File: tb/tb_dmem.sv
// Directed and random check of dmem against a byte-level reference model and a result scoreboard.
// Honours DMEM_BOUNDS_CHECK_EN for the out-of-range expectations.
module tb_dmem;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int SPAN   = DEPTH * 4;
    localparam int MB     = 256;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(ADDR_W)) bus ();

    dmem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  mb [MB];

    function automatic logic f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic model_mis(input logic [31:0] a, input logic [2:0] f3);
        logic m;
        m = !f3_ok(f3);
        if (f3[1:0] == 2'd1 && a[0]) m = 1'b1;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) m = 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (a >= 32'(SPAN)) m = 1'b1;
`endif
        return m;
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'(a % 32'(SPAN)) % MB;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f3);
        int b;
        if (model_mis(a, f3)) return 32'd0;
        b = midx(a);
        case (f3)
            3'b000:  return {{24{mb[b][7]}}, mb[b]};
            3'b100:  return {24'd0, mb[b]};
            3'b001:  return {{16{mb[b+1][7]}}, mb[b+1], mb[b]};
            3'b101:  return {16'd0, mb[b+1], mb[b]};
            3'b010:  return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        int b;
        int n;
        b = midx(a);
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) mb[b+k] = d[8*k +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < MB; i++) mb[i] = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, bus.dataR, e[31:0]);
            check({tag, "_mis"}, {31'd0, bus.misalign}, {31'd0, e[32]});
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rw, input logic [2:0] f3);
        bus.addr   = a;
        bus.dataW  = d;
        bus.MemRW  = rw;
        bus.funct3 = f3;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] exp_data, input logic exp_mis);
        @(negedge clk);
        drive(a, 32'd0, 1'b0, f3);
        exp_q.push_back({exp_mis, exp_data});
        #2;
        sample(tag);
    endtask

    task automatic read_model(input string tag, input logic [31:0] a, input logic [2:0] f3);
        read_chk(tag, a, f3, model_read(a, f3), model_mis(a, f3));
    endtask

    // Old data before the edge, new data right after it, misalign independent of MemRW.
    task automatic write_op(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        logic mis;
        @(negedge clk);
        drive(a, d, 1'b1, f3);
        mis = model_mis(a, f3);
        exp_q.push_back({mis, model_read(a, f3)});
        #2;
        sample({tag, "_pre"});
        @(posedge clk);
        if (!mis) model_write(a, d, f3);
        #1;
        exp_q.push_back({mis, model_read(a, f3)});
        sample({tag, "_post"});
        bus.MemRW = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 3'b010);
        model_clear();
        repeat (2) @(posedge clk);

        // dataR held at zero during reset
        @(negedge clk);
        drive(32'd4, 32'd0, 1'b0, 3'b010);
        exp_q.push_back({1'b0, 32'd0});
        #2;
        sample("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        write_op("sw4", 32'd4, 32'hA5A5_A5A5, 3'b010);
        read_chk("lw4", 32'd4, 3'b010, 32'hA5A5_A5A5, 1'b0);
        write_op("sw8", 32'd8, 32'h00FF_FFFF, 3'b010);
        read_chk("lw8", 32'd8, 3'b010, 32'h00FF_FFFF, 1'b0);
        read_chk("lw4_again", 32'd4, 3'b010, 32'hA5A5_A5A5, 1'b0);
        read_chk("lw12_untouched", 32'd12, 3'b010, 32'h0000_0000, 1'b0);

        write_op("sb9", 32'd9, 32'h0000_0080, 3'b000);
        read_chk("lw8_after_sb", 32'd8, 3'b010, 32'h00FF_80FF, 1'b0);
        read_chk("lb9", 32'd9, 3'b000, 32'hFFFF_FF80, 1'b0);
        read_chk("lbu9", 32'd9, 3'b100, 32'h0000_0080, 1'b0);
        read_chk("lh10", 32'd10, 3'b001, 32'h0000_00FF, 1'b0);

        write_op("sw6_mis", 32'd6, 32'h1234_5678, 3'b010);
        read_chk("lw4_kept", 32'd4, 3'b010, 32'hA5A5_A5A5, 1'b0);
        read_chk("lh5_mis", 32'd5, 3'b001, 32'h0000_0000, 1'b1);
        read_chk("f3_011", 32'd4, 3'b011, 32'h0000_0000, 1'b1);
        read_chk("f3_110", 32'd4, 3'b110, 32'h0000_0000, 1'b1);
        read_chk("lw_off2", 32'd10, 3'b010, 32'h0000_0000, 1'b1);

        write_op("sh6", 32'd6, 32'h0000_BEEF, 3'b001);
        read_chk("lhu6", 32'd6, 3'b101, 32'h0000_BEEF, 1'b0);
        read_chk("lh6", 32'd6, 3'b001, 32'hFFFF_BEEF, 1'b0);
        read_chk("lw4_sh", 32'd4, 3'b010, 32'hBEEF_A5A5, 1'b0);

        // funct3=101 stores as a halfword; an illegal code is dropped
        write_op("sh_f3_101", 32'd0, 32'hFFFF_1234, 3'b101);
        read_chk("lw0", 32'd0, 3'b010, 32'h0000_1234, 1'b0);
        write_op("st_f3_011", 32'd0, 32'hFFFF_FFFF, 3'b011);
        read_chk("lw0_kept", 32'd0, 3'b010, 32'h0000_1234, 1'b0);

`ifdef DMEM_BOUNDS_CHECK_EN
        read_chk("wrap_lw", 32'(SPAN + 4), 3'b010, 32'h0000_0000, 1'b1);
        read_chk("hi_lw", 32'h8000_0004, 3'b010, 32'h0000_0000, 1'b1);
`else
        read_chk("wrap_lw", 32'(SPAN + 4), 3'b010, 32'hBEEF_A5A5, 1'b0);
        read_chk("hi_lw", 32'h8000_0004, 3'b010, 32'hBEEF_A5A5, 1'b0);
`endif
        write_op("wrap_sw", 32'(SPAN + 12), 32'h1122_3344, 3'b010);
        read_model("lw12_wrap", 32'd12, 3'b010);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a  = 32'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) write_op($sformatf("rnd%0d_wr", i), a, $urandom, f3);
            else read_model($sformatf("rnd%0d_rd", i), a, f3);
        end

        // Async reset between edges, with a write held across an edge while in reset
        write_op("sw4_pre_rst", 32'd4, 32'hA5A5_A5A5, 3'b010);
        @(negedge clk);
        drive(32'd4, 32'd0, 1'b0, 3'b010);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        exp_q.push_back({1'b0, 32'd0});
        sample("rst_async");
        drive(32'd4, 32'hDEAD_BEEF, 1'b1, 3'b010);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.MemRW = 1'b0;
        read_chk("rst_lw4", 32'd4, 3'b010, 32'h0000_0000, 1'b0);

        // Reset released on the same edge as a write
        @(negedge clk);
        rst_n = 1'b0;
        drive(32'd16, 32'h55AA_55AA, 1'b1, 3'b010);
        @(posedge clk);
        rst_n = 1'b1;
        #1;
        bus.MemRW = 1'b0;
        read_chk("rst_edge_lw16", 32'd16, 3'b010, 32'h0000_0000, 1'b0);
        write_op("sw16_after", 32'd16, 32'h0BAD_F00D, 3'b010);
        read_chk("lw16_after", 32'd16, 3'b010, 32'h0BAD_F00D, 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
